// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bundle: two write requesters, decode issue/read-select, regfile write port.
// master = requesters/decode side, slave = arbiter side.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              a_valid;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [REG_W-1:0]  b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              issue_valid;
  logic [REG_W-1:0]  issue_reg;
  logic [REG_W-1:0]  rd1_sel;
  logic [REG_W-1:0]  rd2_sel;
  logic              rd1_busy;
  logic              rd2_busy;
  logic              wr_en;
  logic [REG_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              err;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
           issue_valid, issue_reg, rd1_sel, rd2_sel,
    input  a_ready, b_ready, rd1_busy, rd2_busy, wr_en, wr_sel, wr_data, err
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
           issue_valid, issue_reg, rd1_sel, rd2_sel,
    output a_ready, b_ready, rd1_busy, rd2_busy, wr_en, wr_sel, wr_data, err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Purpose: round-robin share of the regfile write port between WB (A) and long-latency unit (B), plus pending-write scoreboard.
// Latency: accepted write drives wr_en/wr_sel/wr_data one cycle later. Backpressure: ready only via arbitration, write stage never stalls.
// Optional contention counter enabled by RF_ARB_STATS_EN.
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
`ifdef RF_ARB_STATS_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  rf_wb_arbiter_if.slave     bus
`ifdef RF_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   conflicts
`endif
);

  localparam int NREG = 2 ** REG_W;

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} rr_t;

  rr_t               rr_ptr, rr_next;
  logic [NREG-1:0]   sb, sb_next, set_mask, clr_mask;
  logic              contend, a_grant, b_grant, err_next;
  logic              rd1_hit, rd2_hit, issue_hit;

  assign contend = bus.a_valid & bus.b_valid;
  assign a_grant = bus.a_valid & (~bus.b_valid | (rr_ptr == PTR_A));
  assign b_grant = bus.b_valid & (~bus.a_valid | (rr_ptr == PTR_B));
  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  // A register committing this cycle is forwarded by the regfile bypass, so it is not busy.
  assign rd1_hit   = bus.wr_en & (bus.wr_sel == bus.rd1_sel);
  assign rd2_hit   = bus.wr_en & (bus.wr_sel == bus.rd2_sel);
  assign issue_hit = bus.wr_en & (bus.wr_sel == bus.issue_reg);
  assign bus.rd1_busy = sb[bus.rd1_sel] & ~rd1_hit;
  assign bus.rd2_busy = sb[bus.rd2_sel] & ~rd2_hit;

  always_comb begin
    rr_next  = rr_ptr;
    set_mask = '0;
    clr_mask = '0;
    if (contend) rr_next = (rr_ptr == PTR_A) ? PTR_B : PTR_A;
    if (bus.issue_valid) set_mask[bus.issue_reg] = 1'b1;
    if (bus.wr_en)       clr_mask[bus.wr_sel]    = 1'b1;
    // Set after clear: a same-cycle issue to the committing register is a new pending write.
    sb_next  = (sb & ~clr_mask) | set_mask;
    err_next = bus.err
             | (bus.issue_valid & sb[bus.issue_reg] & ~issue_hit)
             | (bus.wr_en & ~sb[bus.wr_sel]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= PTR_A;
      sb      <= '0;
      bus.err <= 1'b0;
    end else begin
      rr_ptr  <= rr_next;
      sb      <= sb_next;
      bus.err <= err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_sel  <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= a_grant | b_grant;
      if (a_grant) begin
        bus.wr_sel  <= bus.a_reg;
        bus.wr_data <= bus.a_data;
      end else if (b_grant) begin
        bus.wr_sel  <= bus.b_reg;
        bus.wr_data <= bus.b_data;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflicts <= '0;
    end else if (contend && (conflicts != {CNT_W{1'b1}})) begin
      conflicts <= conflicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes queued at stimulus time, checked by a monitor on wr_en.
// Also checks arbitration order, busy flags, sticky err, async reset and (RF_ARB_STATS_EN) the conflict counter.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  rf_wb_arbiter_if #(.DATA_W(16), .REG_W(3)) ifc ();

`ifdef RF_ARB_STATS_EN
  logic [7:0] conflicts;
  rf_wb_arbiter #(.DATA_W(16), .REG_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .conflicts(conflicts));
`else
  rf_wb_arbiter #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] sel, input logic [15:0] data);
    wr_t e;
    e.sel  = sel;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    ifc.a_valid = 1'b0; ifc.a_reg = '0; ifc.a_data = '0;
    ifc.b_valid = 1'b0; ifc.b_reg = '0; ifc.b_data = '0;
    ifc.issue_valid = 1'b0; ifc.issue_reg = '0;
    ifc.rd1_sel = '0; ifc.rd2_sel = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  // Monitor: every committed write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && ifc.wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got sel=%0d data=%0h expected none", ifc.wr_sel, ifc.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_sel", 32'(ifc.wr_sel), 32'(mon_e.sel));
        chk("wr_data", 32'(ifc.wr_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_wr_en", 32'(ifc.wr_en), 0);
    chk("rst_wr_sel", 32'(ifc.wr_sel), 0);
    chk("rst_wr_data", 32'(ifc.wr_data), 0);
    chk("rst_err", 32'(ifc.err), 0);
    chk("rst_busy", 32'(ifc.rd1_busy), 0);

    // A only: r3 <= 1234 (issued together so the commit is legitimate)
    cyc();
    ifc.a_valid = 1'b1; ifc.a_reg = 3'd3; ifc.a_data = 16'h1234;
    ifc.issue_valid = 1'b1; ifc.issue_reg = 3'd3;
    push(3'd3, 16'h1234);
    @(negedge clk);
    chk("a_only_a_ready", 32'(ifc.a_ready), 1);
    chk("a_only_b_ready", 32'(ifc.b_ready), 0);
    cyc();
    ifc.a_valid = 1'b0; ifc.issue_valid = 1'b0;
    @(negedge clk);
    chk("a_only_wr_en", 32'(ifc.wr_en), 1);
    cyc();
    @(negedge clk);
    chk("a_only_idle_wr_en", 32'(ifc.wr_en), 0);
    chk("a_only_hold_sel", 32'(ifc.wr_sel), 3);
    chk("a_only_err", 32'(ifc.err), 0);

    // Contention: expect A,B,A,B
    do_reset();
    push(3'd1, 16'hAAAA); push(3'd2, 16'hBBBB);
    push(3'd1, 16'hAAAA); push(3'd2, 16'hBBBB);
    ifc.a_valid = 1'b1; ifc.a_reg = 3'd1; ifc.a_data = 16'hAAAA;
    ifc.b_valid = 1'b1; ifc.b_reg = 3'd2; ifc.b_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_a_ready", 32'(ifc.a_ready), (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", 32'(ifc.b_ready), (i % 2 == 1) ? 1 : 0);
      chk("rr_both_ready", 32'(ifc.a_ready & ifc.b_ready), 0);
      cyc();
    end
    ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
    repeat (2) cyc();

    // Scoreboard busy and bypass on r5
    do_reset();
    ifc.issue_valid = 1'b1; ifc.issue_reg = 3'd5; ifc.rd1_sel = 3'd5; ifc.rd2_sel = 3'd5;
    @(negedge clk);
    chk("sb5_busy_issue_cycle", 32'(ifc.rd1_busy), 0);
    cyc();
    ifc.issue_valid = 1'b0;
    @(negedge clk);
    chk("sb5_rd1_busy", 32'(ifc.rd1_busy), 1);
    chk("sb5_rd2_busy", 32'(ifc.rd2_busy), 1);
    cyc();
    ifc.a_valid = 1'b1; ifc.a_reg = 3'd5; ifc.a_data = 16'h5555;
    push(3'd5, 16'h5555);
    @(negedge clk);
    chk("sb5_busy_accept", 32'(ifc.rd1_busy), 1);
    cyc();
    ifc.a_valid = 1'b0;
    @(negedge clk);
    chk("sb5_busy_commit", 32'(ifc.rd1_busy), 0);
    chk("sb5_rd2_commit", 32'(ifc.rd2_busy), 0);
    cyc();
    @(negedge clk);
    chk("sb5_cleared", 32'(ifc.rd1_busy), 0);
    chk("sb5_err", 32'(ifc.err), 0);

    // Same-cycle set and clear of r6: set wins, no error
    cyc();
    ifc.issue_valid = 1'b1; ifc.issue_reg = 3'd6;
    ifc.a_valid = 1'b1; ifc.a_reg = 3'd6; ifc.a_data = 16'h6666;
    push(3'd6, 16'h6666);
    cyc();
    ifc.a_valid = 1'b0;
    cyc();
    ifc.issue_valid = 1'b0; ifc.rd1_sel = 3'd6;
    @(negedge clk);
    chk("sb6_still_busy", 32'(ifc.rd1_busy), 1);
    chk("sb6_err", 32'(ifc.err), 0);
    cyc();
    ifc.a_valid = 1'b1; ifc.a_data = 16'h0606;
    push(3'd6, 16'h0606);
    cyc();
    ifc.a_valid = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("sb6_cleared", 32'(ifc.rd1_busy), 0);
    chk("sb6_err_final", 32'(ifc.err), 0);

    // Double issue of r4 -> sticky err
    cyc();
    ifc.issue_valid = 1'b1; ifc.issue_reg = 3'd4;
    cyc();
    cyc();
    ifc.issue_valid = 1'b0;
    @(negedge clk);
    chk("err_double_issue", 32'(ifc.err), 1);
    repeat (3) cyc();
    @(negedge clk);
    chk("err_sticky", 32'(ifc.err), 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared_by_rst", 32'(ifc.err), 0);

    // B write to idle r7 -> err
    cyc();
    ifc.b_valid = 1'b1; ifc.b_reg = 3'd7; ifc.b_data = 16'h7777;
    push(3'd7, 16'h7777);
    @(negedge clk);
    chk("b_idle_b_ready", 32'(ifc.b_ready), 1);
    chk("b_idle_a_ready", 32'(ifc.a_ready), 0);
    cyc();
    ifc.b_valid = 1'b0;
    @(negedge clk);
    chk("b_idle_err_before", 32'(ifc.err), 0);
    cyc();
    @(negedge clk);
    chk("b_idle_err", 32'(ifc.err), 1);

    // Async reset with write stage loaded
    cyc();
    ifc.a_valid = 1'b1; ifc.a_reg = 3'd2; ifc.a_data = 16'h2222;
    cyc();
    ifc.a_valid = 1'b0;
    chk("loaded_wr_en", 32'(ifc.wr_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 32'(ifc.wr_en), 0);
    chk("async_rst_wr_data", 32'(ifc.wr_data), 0);
    chk("async_rst_err", 32'(ifc.err), 0);
    repeat (2) cyc();
    rst = 1'b0;

`ifdef RF_ARB_STATS_EN
    do_reset();
    ifc.a_valid = 1'b1; ifc.a_reg = 3'd1; ifc.a_data = 16'hAAAA;
    ifc.b_valid = 1'b1; ifc.b_reg = 3'd2; ifc.b_data = 16'hBBBB;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) push(3'd1, 16'hAAAA);
      else push(3'd2, 16'hBBBB);
    end
    repeat (300) cyc();
    ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
    @(negedge clk);
    chk("conflicts_saturate", 32'(conflicts), 255);
`endif

    repeat (3) cyc();
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
